// File: rtl/cpu_mem_arbiter_if.sv
// Fetch, data and Wishbone signals of the CPU memory arbiter.
// Signal suffixes are from the arbiter's point of view.
interface cpu_mem_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_adr_i;
  logic        if_ack_o;
  logic        if_err_o;
  logic [31:0] if_dat_o;

  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_adr_i;
  logic [31:0] d_dat_i;
  logic [3:0]  d_sel_i;
  logic        d_lock_i;
  logic        d_ack_o;
  logic        d_err_o;
  logic [31:0] d_dat_o;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  // The arbiter masters the Wishbone port.
  modport master (
    input  if_req_i, if_adr_i,
    output if_ack_o, if_err_o, if_dat_o,
    input  d_req_i, d_we_i, d_adr_i, d_dat_i, d_sel_i, d_lock_i,
    output d_ack_o, d_err_o, d_dat_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  // The CPU pipeline and the memory slave seen together.
  modport slave (
    output if_req_i, if_adr_i,
    input  if_ack_o, if_err_o, if_dat_o,
    output d_req_i, d_we_i, d_adr_i, d_dat_i, d_sel_i, d_lock_i,
    input  d_ack_o, d_err_o, d_dat_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Shares one Wishbone-classic port between instruction fetch and the data stage.
// Data has priority, fetch is protected from starvation, and lock keeps stack sequences atomic.
module cpu_mem_arbiter #(
  parameter int unsigned FAIRNESS_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk_i,
  input logic               rst_i,
  cpu_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2
  } state_e;

  localparam logic [3:0] STREAK_MAX = 4'(FAIRNESS_LIMIT);
  localparam logic [7:0] WDOG_MAX   = 8'(TIMEOUT_CYCLES);
  localparam logic       WDOG_EN    = (TIMEOUT_CYCLES != 0);

  state_e      state_q, state_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        wb_stb_q, wb_stb_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic        if_ack_q, if_ack_d;
  logic        if_err_q, if_err_d;
  logic [31:0] if_dat_q, if_dat_d;
  logic        d_ack_q, d_ack_d;
  logic        d_err_q, d_err_d;
  logic [31:0] d_dat_q, d_dat_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  wdog_q, wdog_d;

  logic if_live, d_live, grant_d, grant_if;
  logic xfer_ack, xfer_tmo, lock_gap, lock_start, lock_release;

  // A requester still showing its ack/err is presenting a stale request.
  assign if_live      = bus.if_req_i & ~if_ack_q & ~if_err_q;
  assign d_live       = bus.d_req_i & ~d_ack_q & ~d_err_q;
  assign grant_d      = d_live & ~(if_live & (streak_q == STREAK_MAX));
  assign grant_if     = if_live & ~grant_d;
  assign xfer_ack     = wb_stb_q & bus.wb_ack_i;
  assign xfer_tmo     = wb_stb_q & ~bus.wb_ack_i & WDOG_EN & (wdog_q == WDOG_MAX);
  assign lock_gap     = (state_q == GNT_D) & ~wb_stb_q;
  assign lock_start   = lock_gap & bus.d_req_i & ~d_ack_q;
  assign lock_release = lock_gap & ~lock_start & ~bus.d_lock_i;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wb_cyc_q <= 1'b0;
      wb_stb_q <= 1'b0;
      wb_we_q  <= 1'b0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_sel_q <= '0;
      if_ack_q <= 1'b0;
      if_err_q <= 1'b0;
      if_dat_q <= '0;
      d_ack_q  <= 1'b0;
      d_err_q  <= 1'b0;
      d_dat_q  <= '0;
      streak_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      wb_cyc_q <= wb_cyc_d;
      wb_stb_q <= wb_stb_d;
      wb_we_q  <= wb_we_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      wb_sel_q <= wb_sel_d;
      if_ack_q <= if_ack_d;
      if_err_q <= if_err_d;
      if_dat_q <= if_dat_d;
      d_ack_q  <= d_ack_d;
      d_err_q  <= d_err_d;
      d_dat_q  <= d_dat_d;
      streak_q <= streak_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)       state_d = GNT_D;
        else if (grant_if) state_d = GNT_IF;
      end
      GNT_IF: if (xfer_ack || xfer_tmo) state_d = IDLE;
      GNT_D: begin
        if ((xfer_ack && !bus.d_lock_i) || xfer_tmo || lock_release) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every _d gets a default before the case so no path infers a latch.
    wb_cyc_d = wb_cyc_q;
    wb_stb_d = wb_stb_q;
    wb_we_d  = wb_we_q;
    wb_adr_d = wb_adr_q;
    wb_dat_d = wb_dat_q;
    wb_sel_d = wb_sel_q;
    if_ack_d = 1'b0;
    if_err_d = 1'b0;
    if_dat_d = if_dat_q;
    d_ack_d  = 1'b0;
    d_err_d  = 1'b0;
    d_dat_d  = d_dat_q;
    streak_d = bus.if_req_i ? streak_q : 4'd0;
    wdog_d   = wdog_q;

    case (state_q)
      IDLE: begin
        if (grant_d) begin
          wb_cyc_d = 1'b1;
          wb_stb_d = 1'b1;
          wb_we_d  = bus.d_we_i;
          wb_adr_d = bus.d_adr_i;
          wb_dat_d = bus.d_dat_i;
          wb_sel_d = bus.d_sel_i;
          wdog_d   = '0;
          if (bus.if_req_i) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
          end
        end else if (grant_if) begin
          wb_cyc_d = 1'b1;
          wb_stb_d = 1'b1;
          wb_we_d  = 1'b0;
          wb_adr_d = bus.if_adr_i;
          wb_dat_d = '0;
          wb_sel_d = 4'hF;
          wdog_d   = '0;
          streak_d = '0;
        end
      end
      GNT_IF, GNT_D: begin
        if (xfer_ack) begin
          wb_stb_d = 1'b0;
          if (state_q == GNT_IF) begin
            if_ack_d = 1'b1;
            if_dat_d = bus.wb_dat_i;
            wb_cyc_d = 1'b0;
          end else begin
            d_ack_d  = 1'b1;
            d_dat_d  = bus.wb_dat_i;
            wb_cyc_d = bus.d_lock_i;
          end
        end else if (xfer_tmo) begin
          wb_cyc_d = 1'b0;
          wb_stb_d = 1'b0;
          if (state_q == GNT_IF) if_err_d = 1'b1;
          else                   d_err_d  = 1'b1;
        end else if (wb_stb_q) begin
          if (wdog_q != 8'hFF) wdog_d = wdog_q + 8'd1;
        end else if (lock_start) begin
          // Next word of a locked sequence: bus cycle already open.
          wb_stb_d = 1'b1;
          wb_we_d  = bus.d_we_i;
          wb_adr_d = bus.d_adr_i;
          wb_dat_d = bus.d_dat_i;
          wb_sel_d = bus.d_sel_i;
          wdog_d   = '0;
        end else if (lock_release) begin
          wb_cyc_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.wb_cyc_o = wb_cyc_q;
  assign bus.wb_stb_o = wb_stb_q;
  assign bus.wb_we_o  = wb_we_q;
  assign bus.wb_adr_o = wb_adr_q;
  assign bus.wb_dat_o = wb_dat_q;
  assign bus.wb_sel_o = wb_sel_q;
  assign bus.if_ack_o = if_ack_q;
  assign bus.if_err_o = if_err_q;
  assign bus.if_dat_o = if_dat_q;
  assign bus.d_ack_o  = d_ack_q;
  assign bus.d_err_o  = d_err_q;
  assign bus.d_dat_o  = d_dat_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios plus randomized traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_cpu_mem_arbiter;
  localparam int FAIR = 4;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_mem_arbiter_if bus ();

  cpu_mem_arbiter #(
    .FAIRNESS_LIMIT(FAIR),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus and what the bus/response registers hold.
  typedef enum int {OWN_NONE, OWN_IF, OWN_D} owner_e;
  owner_e     m_owner;
  bit         m_cyc, m_stb, m_we;
  bit [31:0]  m_adr, m_wdat;
  bit [3:0]   m_sel;
  bit         m_if_ack, m_if_err, m_d_ack, m_d_err;
  bit [31:0]  m_if_dat, m_d_dat;
  int         m_streak, m_wait;

  task automatic model_reset();
    m_owner = OWN_NONE;
    {m_cyc, m_stb, m_we} = '0;
    m_adr = '0; m_wdat = '0; m_sel = '0;
    {m_if_ack, m_if_err, m_d_ack, m_d_err} = '0;
    m_if_dat = '0; m_d_dat = '0;
    m_streak = 0; m_wait = 0;
  endtask

  task automatic model_start(input owner_e who);
    m_owner = who;
    m_cyc   = 1'b1;
    m_stb   = 1'b1;
    m_wait  = 0;
    if (who == OWN_D) begin
      m_we = bus.d_we_i; m_adr = bus.d_adr_i; m_wdat = bus.d_dat_i; m_sel = bus.d_sel_i;
    end else begin
      m_we = 1'b0; m_adr = bus.if_adr_i; m_wdat = '0; m_sel = 4'hF;
    end
  endtask

  // Advance the model by one clock using the inputs presented for the coming edge.
  task automatic model_step();
    bit if_stale, d_stale, d_acked, stb, f_want, d_want;
    int streak, wait_cnt;
    if_stale = m_if_ack || m_if_err;
    d_stale  = m_d_ack || m_d_err;
    d_acked  = m_d_ack;
    stb      = m_stb;
    streak   = m_streak;
    wait_cnt = m_wait;
    {m_if_ack, m_if_err, m_d_ack, m_d_err} = '0;
    m_streak = bus.if_req_i ? streak : 0;
    if (m_owner == OWN_NONE) begin
      f_want = bus.if_req_i && !if_stale;
      d_want = bus.d_req_i && !d_stale;
      if (d_want && !(f_want && streak == FAIR)) begin
        model_start(OWN_D);
        if (bus.if_req_i) m_streak = (streak < FAIR) ? streak + 1 : FAIR;
      end else if (f_want) begin
        model_start(OWN_IF);
        m_streak = 0;
      end
    end else if (stb) begin
      if (bus.wb_ack_i) begin
        m_stb = 1'b0;
        if (m_owner == OWN_IF) begin m_if_ack = 1'b1; m_if_dat = bus.wb_dat_i; end
        else begin m_d_ack = 1'b1; m_d_dat = bus.wb_dat_i; end
        if (!(m_owner == OWN_D && bus.d_lock_i)) begin m_cyc = 1'b0; m_owner = OWN_NONE; end
      end else if (TMO != 0 && wait_cnt == TMO) begin
        if (m_owner == OWN_IF) m_if_err = 1'b1; else m_d_err = 1'b1;
        m_cyc = 1'b0; m_stb = 1'b0; m_owner = OWN_NONE;
      end else begin
        m_wait = wait_cnt + 1;
      end
    end else if (bus.d_req_i && !d_acked) begin
      model_start(OWN_D);
    end else if (!bus.d_lock_i) begin
      m_cyc = 1'b0; m_owner = OWN_NONE;
    end
  endtask

  task automatic compare_all();
    check("ctl", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, {m_cyc, m_stb, m_we});
    check("adr", bus.wb_adr_o, m_adr);
    check("wdat", bus.wb_dat_o, m_wdat);
    check("sel", bus.wb_sel_o, m_sel);
    check("rsp", {bus.if_ack_o, bus.if_err_o, bus.d_ack_o, bus.d_err_o},
          {m_if_ack, m_if_err, m_d_ack, m_d_err});
    check("if_dat", bus.if_dat_o, m_if_dat);
    check("d_dat", bus.d_dat_o, m_d_dat);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Zero-wait slave: acknowledge every cycle the strobe is up.
  task automatic zstep();
    bus.wb_ack_i = m_stb;
    step();
  endtask

  task automatic idle_inputs();
    bus.if_req_i = 1'b0; bus.if_adr_i = '0;
    bus.d_req_i = 1'b0; bus.d_we_i = 1'b0; bus.d_adr_i = '0; bus.d_dat_i = '0;
    bus.d_sel_i = '0; bus.d_lock_i = 1'b0;
    bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0;
  endtask

  task automatic new_data_req();
    bus.d_we_i   = $urandom_range(0, 1);
    bus.d_sel_i  = 4'($urandom);
    bus.d_lock_i = ($urandom % 4 == 0);
  endtask

  int  run_len, n_if_gnt, n_d_gnt;
  bit  prev_stb, stb_seen, s_hang;
  int  s_wait;

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    #2 rst = 1'b0;

    // 1: single fetch, zero-wait slave
    bus.if_req_i = 1'b1; bus.if_adr_i = 32'h0000_1000; bus.wb_dat_i = 32'hDEAD_BEEF;
    zstep();
    check("t1_stb_cycle1", bus.wb_stb_o, 1'b1);
    check("t1_sel", bus.wb_sel_o, 4'hF);
    check("t1_adr", bus.wb_adr_o, 32'h0000_1000);
    zstep();
    check("t1_ack_cycle2", bus.if_ack_o, 1'b1);
    check("t1_if_dat", bus.if_dat_o, 32'hDEAD_BEEF);
    bus.if_req_i = 1'b0;
    zstep();
    zstep();

    // 2: simultaneous requests, data wins, fetch follows the data ack
    bus.if_req_i = 1'b1; bus.if_adr_i = 32'h0000_1004;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_adr_i = 32'h0000_2000;
    bus.d_dat_i = 32'h1234_5678; bus.d_sel_i = 4'h3; bus.wb_dat_i = 32'h0BAD_F00D;
    zstep();
    check("t2_d_first", {bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o}, {1'b1, 1'b1, 4'h3});
    check("t2_d_adr", bus.wb_adr_o, 32'h0000_2000);
    check("t2_d_wdat", bus.wb_dat_o, 32'h1234_5678);
    zstep();
    check("t2_d_ack", {bus.d_ack_o, bus.wb_cyc_o}, 2'b10);
    bus.d_req_i = 1'b0;
    zstep();
    check("t2_if_next", {bus.wb_stb_o, bus.wb_we_o}, 2'b10);
    check("t2_if_adr", bus.wb_adr_o, 32'h0000_1004);
    zstep();
    check("t2_if_ack", bus.if_ack_o, 1'b1);
    idle_inputs();
    zstep();

    // 3: data held continuously with fetch pending; fetch must never starve
    bus.if_req_i = 1'b1; bus.if_adr_i = 32'h0000_0100;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_adr_i = 32'h0000_0200; bus.d_sel_i = 4'hF;
    run_len = 0; n_if_gnt = 0; n_d_gnt = 0; prev_stb = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bus.wb_dat_i = $urandom;
      zstep();
      if (bus.wb_stb_o && !prev_stb) begin
        if (bus.wb_adr_o == 32'h0000_0200) begin
          run_len++; n_d_gnt++;
        end else begin
          check("t3_data_run_le_limit", run_len <= FAIR, 1'b1);
          run_len = 0; n_if_gnt++;
        end
      end
      prev_stb = bus.wb_stb_o;
    end
    check("t3_fetch_served", n_if_gnt >= 3, 1'b1);
    check("t3_data_served", n_d_gnt >= 3, 1'b1);
    idle_inputs();
    zstep(); zstep();

    // 4: locked JSR pair; cyc stays up and fetch waits for the release
    bus.if_req_i = 1'b1; bus.if_adr_i = 32'h0000_3000;
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b1; bus.d_adr_i = 32'h0000_0FF8;
    bus.d_dat_i = 32'hAAAA_0001; bus.d_sel_i = 4'hF; bus.d_lock_i = 1'b1;
    zstep();
    check("t4_w1", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b11);
    check("t4_w1_adr", bus.wb_adr_o, 32'h0000_0FF8);
    zstep();
    check("t4_w1_ack", {bus.wb_cyc_o, bus.wb_stb_o, bus.d_ack_o}, 3'b101);
    bus.d_adr_i = 32'h0000_0FFC; bus.d_dat_i = 32'hAAAA_0002;
    zstep();
    check("t4_gap", {bus.wb_cyc_o, bus.wb_stb_o, bus.d_ack_o}, 3'b100);
    zstep();
    check("t4_w2", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b11);
    check("t4_w2_adr", bus.wb_adr_o, 32'h0000_0FFC);
    zstep();
    check("t4_w2_ack", {bus.wb_cyc_o, bus.d_ack_o}, 2'b11);
    bus.d_lock_i = 1'b0; bus.d_req_i = 1'b0;
    zstep();
    check("t4_release", bus.wb_cyc_o, 1'b0);
    zstep();
    check("t4_if_after", {bus.wb_stb_o, bus.wb_we_o}, 2'b10);
    check("t4_if_adr", bus.wb_adr_o, 32'h0000_3000);
    zstep();
    idle_inputs();
    zstep();

    // 5: slave never acknowledges
    bus.d_req_i = 1'b1; bus.d_we_i = 1'b0; bus.d_adr_i = 32'h0000_0500; bus.d_sel_i = 4'hF;
    bus.wb_ack_i = 1'b0;
    step();
    check("t5_stb", bus.wb_stb_o, 1'b1);
    for (int k = 1; k <= TMO; k++) begin
      step();
      check("t5_waiting", {bus.wb_stb_o, bus.d_err_o}, 2'b10);
    end
    step();
    check("t5_err", {bus.wb_cyc_o, bus.wb_stb_o, bus.d_err_o, bus.d_ack_o}, 4'b0010);
    bus.d_req_i = 1'b0;
    step();
    check("t5_idle_after", {bus.wb_cyc_o, bus.d_err_o}, 2'b00);

    // 6: reset while a transfer is waiting for its ack
    bus.d_req_i = 1'b1; bus.d_adr_i = 32'h0000_0400; bus.wb_dat_i = 32'h5555_AAAA;
    step();
    check("t6_stb_before", bus.wb_stb_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_drop", {bus.wb_cyc_o, bus.wb_stb_o}, 2'b00);
    model_reset();
    @(posedge clk);
    #1;
    compare_all();
    check("t6_no_rsp", {bus.if_ack_o, bus.if_err_o, bus.d_ack_o, bus.d_err_o}, 4'b0000);
    #2 rst = 1'b0;
    zstep();
    check("t6_restart", {bus.wb_stb_o, bus.wb_adr_o[15:0]}, {1'b1, 16'h0400});
    zstep();
    check("t6_ack", {bus.d_ack_o, bus.d_dat_o}, {1'b1, 32'h5555_AAAA});
    idle_inputs();
    zstep();

    // Randomized traffic: random requesters, wait states, hangs and stray acks
    stb_seen = 1'b0; s_hang = 1'b0; s_wait = 0;
    for (int c = 0; c < 4000; c++) begin
      if (m_if_ack || m_if_err) bus.if_req_i = $urandom_range(0, 1);
      else if (!bus.if_req_i)   bus.if_req_i = ($urandom % 3 == 0);
      bus.if_adr_i = $urandom;

      if (m_d_ack || m_d_err) begin
        bus.d_req_i = $urandom_range(0, 1);
        new_data_req();
      end else if (!bus.d_req_i) begin
        if ($urandom % 3 == 0) begin
          bus.d_req_i = 1'b1;
          new_data_req();
        end else if ($urandom % 3 == 0) begin
          bus.d_lock_i = 1'b0;
        end
      end
      bus.d_adr_i = $urandom;
      bus.d_dat_i = $urandom;

      if (m_stb) begin
        if (!stb_seen) begin
          stb_seen = 1'b1;
          s_hang   = ($urandom % 10 == 0);
          s_wait   = $urandom_range(0, 3);
        end
        bus.wb_ack_i = !s_hang && (s_wait == 0);
        if (s_wait > 0) s_wait--;
      end else begin
        stb_seen     = 1'b0;
        bus.wb_ack_i = ($urandom % 6 == 0);
      end
      bus.wb_dat_i = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
